frame_minmax: RTL and testbench

Streaming min/max reducer that sits directly downstream of the team's 32-bit magnitude Comparator. It accepts a valid/ready stream of unsigned words grouped into frames by a last flag. For each frame it reports the minimum, the maximum and the beat count, then holds that result until the consumer accepts it. Two Comparator instances do the per-beat decisions; this block adds the sequencing, state and handshakes.

---
 rtl/frame_minmax_pkg.sv | 14 +
 rtl/frame_minmax_comparator.sv | 13 +
 rtl/frame_minmax.sv | 134 +++++++++++++
 tb/tb_frame_minmax.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_minmax_pkg.sv
// Shared types and constants for the frame_minmax reducer.
// The FSM encoding and counter saturation value live here so every file agrees on them.
package frame_minmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int               CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};

endpackage

// File: rtl/frame_minmax_comparator.sv
// 32-bit unsigned magnitude comparator: flags a < b and a > b.
// Purely combinational; ties raise neither flag.
module frame_minmax_comparator (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        lt,
    output logic        gt
);

    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/frame_minmax.sv
// Streaming per-frame min/max/beat-count reducer with valid/ready handshakes on both sides.
// Define FRAME_MINMAX_IDX_EN to add first-occurrence beat indices for the min and max.
module frame_minmax
    import frame_minmax_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
`ifdef FRAME_MINMAX_IDX_EN
    output logic [CNT_W-1:0]  out_min_idx,
    output logic [CNT_W-1:0]  out_max_idx,
`endif
    output logic [CNT_W-1:0]  out_count
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_SAT) ? c : c + 1'b1;
    endfunction

    state_t            state;
    logic [DATA_W-1:0] min_r;
    logic [DATA_W-1:0] max_r;
    logic [CNT_W-1:0]  cnt_r;
`ifdef FRAME_MINMAX_IDX_EN
    logic [CNT_W-1:0]  min_idx_r;
    logic [CNT_W-1:0]  max_idx_r;
`endif

    logic        accept;
    logic        is_lower;
    logic        is_greater;
    logic [31:0] data_ext;
    logic [31:0] min_ext;
    logic [31:0] max_ext;

    // Narrower samples are zero-extended onto the comparator's fixed 32-bit ports.
    assign data_ext = 32'(in_data);
    assign min_ext  = 32'(min_r);
    assign max_ext  = 32'(max_r);

    frame_minmax_comparator u_cmp_min (
        .a  (data_ext),
        .b  (min_ext),
        .lt (is_lower),
        .gt ()
    );

    frame_minmax_comparator u_cmp_max (
        .a  (data_ext),
        .b  (max_ext),
        .lt (),
        .gt (is_greater)
    );

    assign in_ready  = !rst && (state != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            min_r     <= '0;
            max_r     <= '0;
            cnt_r     <= '0;
`ifdef FRAME_MINMAX_IDX_EN
            min_idx_r <= '0;
            max_idx_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        min_r     <= in_data;
                        max_r     <= in_data;
                        cnt_r     <= sat_inc('0);
`ifdef FRAME_MINMAX_IDX_EN
                        min_idx_r <= '0;
                        max_idx_r <= '0;
`endif
                        state     <= in_last ? HOLD : ACC;
                    end
                end
                ACC: begin
                    // Ties leave min/max untouched so the earliest index is kept.
                    if (accept) begin
                        if (is_lower) begin
                            min_r     <= in_data;
`ifdef FRAME_MINMAX_IDX_EN
                            min_idx_r <= cnt_r;
`endif
                        end
                        if (is_greater) begin
                            max_r     <= in_data;
`ifdef FRAME_MINMAX_IDX_EN
                            max_idx_r <= cnt_r;
`endif
                        end
                        cnt_r <= sat_inc(cnt_r);
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_min   = min_r;
    assign out_max   = max_r;
    assign out_count = cnt_r;
`ifdef FRAME_MINMAX_IDX_EN
    assign out_min_idx = min_idx_r;
    assign out_max_idx = max_idx_r;
`endif

endmodule

// File: tb/tb_frame_minmax.sv
// Bench for frame_minmax: directed and random frames against a queue-based reference model.
// A second instance with CNT_W=4 shares the stimulus to exercise count saturation.
module tb_frame_minmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  out_valid;
    logic [31:0] out_min,   out_max;
    logic [15:0] out_count;
    logic        in_ready4, out_valid4;
    logic [31:0] out_min4,  out_max4;
    logic [3:0]  out_count4;
`ifdef FRAME_MINMAX_IDX_EN
    logic [15:0] out_min_idx, out_max_idx;
    logic [3:0]  out_min_idx4, out_max_idx4;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    frame_minmax #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_min(out_min), .out_max(out_max),
`ifdef FRAME_MINMAX_IDX_EN
        .out_min_idx(out_min_idx), .out_max_idx(out_max_idx),
`endif
        .out_count(out_count)
    );

    frame_minmax #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
        .out_ready(out_ready), .out_min(out_min4), .out_max(out_max4),
`ifdef FRAME_MINMAX_IDX_EN
        .out_min_idx(out_min_idx4), .out_max_idx(out_max_idx4),
`endif
        .out_count(out_count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected results straight from the frame contents: min/max of the set,
    // first position of each, and the beat count clipped to the counter range.
    task automatic model(input logic [31:0] q[$], input int unsigned cap,
                         output logic [31:0] mn, output logic [31:0] mx,
                         output int unsigned cnt, output int unsigned mi,
                         output int unsigned xi);
        logic [31:0] t[$];
        int          p[$];
        t  = q.min();
        mn = t[0];
        t  = q.max();
        mx = t[0];
        p  = q.find_first_index(x) with (x == mn);
        mi = (p[0] < cap) ? p[0] : cap;
        p  = q.find_first_index(x) with (x == mx);
        xi = (p[0] < cap) ? p[0] : cap;
        cnt = (q.size() < cap) ? q.size() : cap;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("beat_timeout", 64'd1, 64'd0);
        chk("ready_lockstep", in_ready4, in_ready);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic check_result(input logic [31:0] q[$]);
        logic [31:0] mn, mx;
        int unsigned cnt, mi, xi;
        model(q, 65535, mn, mx, cnt, mi, xi);
        chk("out_valid", out_valid, 1'b1);
        chk("in_ready_hold", in_ready, 1'b0);
        chk("min", out_min, mn);
        chk("max", out_max, mx);
        chk("count", out_count, cnt);
`ifdef FRAME_MINMAX_IDX_EN
        chk("min_idx", out_min_idx, mi);
        chk("max_idx", out_max_idx, xi);
`endif
        model(q, 15, mn, mx, cnt, mi, xi);
        chk("min4", out_min4, mn);
        chk("max4", out_max4, mx);
        chk("count4", out_count4, cnt);
`ifdef FRAME_MINMAX_IDX_EN
        chk("min_idx4", out_min_idx4, mi);
        chk("max_idx4", out_max_idx4, xi);
`endif
    endtask

    task automatic run_frame(input logic [31:0] q[$], input int holdoff, input bit gaps);
        logic [31:0] mn_hold;
        foreach (q[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_data = $urandom;
                @(posedge clk); #1;
            end
            beat(q[i], (i == q.size() - 1));
        end
        check_result(q);
        mn_hold = out_min;
        if (holdoff > 0) begin
            out_ready = 1'b0;
            for (int k = 0; k < holdoff; k++) begin
                @(posedge clk); #1;
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_min", out_min, mn_hold);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_accept_valid", out_valid, 1'b0);
        chk("post_accept_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] q[$];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_min", out_min, 32'd0);
        chk("rst_max", out_max, 32'd0);
        chk("rst_count", out_count, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_valid", out_valid, 1'b0);

        q = '{32'd5, 32'd3, 32'd9, 32'd3};
        run_frame(q, 0, 1'b0);

        q = '{32'hFFFF_FFFF};
        run_frame(q, 0, 1'b0);

        // Result backpressure with the next frame's first beat waiting.
        out_ready = 1'b0;
        beat(32'd20, 1'b0);
        beat(32'd30, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd100;
        in_last  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_min", out_min, 32'd20);
            chk("bp_max", out_max, 32'd30);
            chk("bp_count", out_count, 16'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_accept_valid", out_valid, 1'b0);
        chk("bp_accept_ready", in_ready, 1'b1);
        chk("bp_min_kept", out_min, 32'd20);
        @(posedge clk); #1;
        chk("bp_first_count", out_count, 16'd1);
        chk("bp_first_min", out_min, 32'd100);
        in_data = 32'd50;
        in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        q = '{32'd100, 32'd50};
        check_result(q);
        @(posedge clk); #1;
        chk("bp_done_valid", out_valid, 1'b0);

        q = '{32'd7, 32'd7, 32'd7};
        run_frame(q, 0, 1'b0);

        // Reset mid-frame discards the partial result.
        beat(32'd10, 1'b0);
        beat(32'd2, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b0);
        chk("mid_rst_min", out_min, 32'd0);
        chk("mid_rst_max", out_max, 32'd0);
        chk("mid_rst_count", out_count, 16'd0);
        rst = 1'b0;
        q = '{32'd4};
        run_frame(q, 0, 1'b0);

        q = {};
        for (int i = 0; i < 20; i++) q.push_back($urandom);
        run_frame(q, 0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 24)); i++)
                q.push_back((f % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom);
            run_frame(q, $urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
